// File: rtl/damage_bcd_converter.sv
// damage_bcd_converter: sequential binary-to-BCD converter for the damage display.
// Converts a saturated damage value into three BCD digits by shift-add-3 (double dabble),
// one bit per clock. Optional feature macro: DMG_SEG_MASK_EN adds registered 7-segment
// masks (bit0=a .. bit6=g, active-high) alongside the digits.
`timescale 1ns/1ps
module damage_bcd_converter #(
    parameter int DATA_W  = 16,
    parameter int MAX_VAL = 999
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] damage_in,
    output logic              busy,
    output logic              done,
    output logic [3:0]        digit100,
    output logic [3:0]        digit10,
    output logic [3:0]        digit1,
    output logic              overflow
`ifdef DMG_SEG_MASK_EN
    ,
    output logic [6:0]        seg100,
    output logic [6:0]        seg10,
    output logic [6:0]        seg1
`endif
);

    localparam int                CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] MAX_W = DATA_W'(MAX_VAL);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] val;
    logic [11:0]       scratch;
    logic [11:0]       scratch_step;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_pend;
    logic              accept;
    logic              last_step;

    // Clamp to the largest value three digits can show.
    function automatic logic [DATA_W-1:0] sat_val(input logic [DATA_W-1:0] v);
        return (v > MAX_W) ? MAX_W : v;
    endfunction

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
    function automatic logic [11:0] dabble(input logic [11:0] s, input logic b);
        logic [11:0] adj;
        adj = s;
        for (int i = 0; i < 3; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end
        end
        return {adj[10:0], b};
    endfunction

`ifdef DMG_SEG_MASK_EN
    // BCD digit to segment mask, bit0=a .. bit6=g.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction
`endif

    assign accept       = start && (state != CONV);
    assign last_step    = (state == CONV) && (cnt == LAST);
    assign scratch_step = dabble(scratch, val[DATA_W-1]);
    assign busy         = (state == CONV);
    assign done         = (state == DONE);

    // State register; reset wins over a simultaneous start.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start is honoured from IDLE and DONE, ignored while converting.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CONV;
            CONV:    if (cnt == LAST) next_state = DONE;
            DONE:    next_state = start ? CONV : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Conversion datapath: capture on accept, one shift-add-3 step per CONV cycle.
    always_ff @(posedge clock) begin
        if (accept) begin
            val      <= sat_val(damage_in);
            ovf_pend <= (damage_in > MAX_W);
            scratch  <= '0;
            cnt      <= '0;
        end else if (state == CONV) begin
            val      <= val << 1;
            scratch  <= scratch_step;
            cnt      <= cnt + 1'b1;
        end
    end

    // Result registers: load only on the final step so they never move mid-conversion.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            digit100 <= '0;
            digit10  <= '0;
            digit1   <= '0;
            overflow <= 1'b0;
`ifdef DMG_SEG_MASK_EN
            seg100   <= 7'h3F;
            seg10    <= 7'h3F;
            seg1     <= 7'h3F;
`endif
        end else if (last_step) begin
            digit100 <= scratch_step[11:8];
            digit10  <= scratch_step[7:4];
            digit1   <= scratch_step[3:0];
            overflow <= ovf_pend;
`ifdef DMG_SEG_MASK_EN
            seg100   <= seg_code(scratch_step[11:8]);
            seg10    <= seg_code(scratch_step[7:4]);
            seg1     <= seg_code(scratch_step[3:0]);
`endif
        end
    end

endmodule

// File: tb/tb_damage_bcd_converter.sv
// Scoreboard testbench for damage_bcd_converter: the driver pushes decimal-model results,
// a negedge monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_damage_bcd_converter;

    localparam int DATA_W = 16;

    typedef struct {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic       ov;
    } exp_t;

    logic              clock = 1'b0;
    logic              resetn;
    logic              start;
    logic [DATA_W-1:0] damage_in;
    logic              busy;
    logic              done;
    logic [3:0]        digit100;
    logic [3:0]        digit10;
    logic [3:0]        digit1;
    logic              overflow;
`ifdef DMG_SEG_MASK_EN
    logic [6:0]        seg100;
    logic [6:0]        seg10;
    logic [6:0]        seg1;
`endif

    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    exp_t sbq[$];
    exp_t got_e;
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    damage_bcd_converter #(.DATA_W(DATA_W), .MAX_VAL(999)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .damage_in(damage_in),
        .busy     (busy),
        .done     (done),
        .digit100 (digit100),
        .digit10  (digit10),
        .digit1   (digit1),
        .overflow (overflow)
`ifdef DMG_SEG_MASK_EN
        ,
        .seg100   (seg100),
        .seg10    (seg10),
        .seg1     (seg1)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain decimal arithmetic on the saturated value.
    function automatic exp_t model(input int unsigned v);
        exp_t e;
        int unsigned s;
        e.ov = (v > 999);
        s    = e.ov ? 999 : v;
        e.h  = 4'(s / 100);
        e.t  = 4'((s / 10) % 10);
        e.o  = 4'(s % 10);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                got_e = sbq.pop_front();
                check("digit100", int'(digit100), int'(got_e.h));
                check("digit10", int'(digit10), int'(got_e.t));
                check("digit1", int'(digit1), int'(got_e.o));
                check("overflow", int'(overflow), int'(got_e.ov));
`ifdef DMG_SEG_MASK_EN
                check("seg100", int'(seg100), int'(seg_tab[got_e.h]));
                check("seg10", int'(seg10), int'(seg_tab[got_e.t]));
                check("seg1", int'(seg1), int'(seg_tab[got_e.o]));
`endif
            end
        end
    end

    // Issue one conversion from an idle DUT and wait for its done pulse.
    task automatic run_one(input int unsigned v, input bit chk_time);
        int n;
        int b;
        @(negedge clock);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        damage_in = v[DATA_W-1:0];
        start     = 1'b1;
        sbq.push_back(model(v));
        @(negedge clock);
        start = 1'b0;
        n = 1;
        b = busy ? 1 : 0;
        while (!done && n < 60) begin
            @(negedge clock);
            n++;
            if (busy) b++;
        end
        if (n >= 60) check("done_timeout", n, 17);
        if (chk_time) begin
            check("done_cycle", n, 17);
            check("busy_cycles", b, 16);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_digits"}, int'({digit100, digit10, digit1}), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
`ifdef DMG_SEG_MASK_EN
        check({tag, "_segs"}, int'({seg100, seg10, seg1}), int'({7'h3F, 7'h3F, 7'h3F}));
`endif
    endtask

    initial begin
        int dc0;
        int gap;
        int n;
        int unsigned v;

        // Reset with start asserted: reset must win.
        resetn    = 1'b0;
        start     = 1'b1;
        damage_in = 16'd321;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        resetn = 1'b1;
        start  = 1'b0;

        run_one(0, 1'b1);
        run_one(123, 1'b1);
        run_one(1000, 1'b0);
        run_one(32'hFFFF, 1'b0);
        run_one(999, 1'b0);

        // Start during conversion is ignored and not queued.
        @(negedge clock);
        damage_in = 16'd287;
        start     = 1'b1;
        sbq.push_back(model(287));
        dc0 = done_cnt;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        damage_in = 16'd50;
        start     = 1'b1;
        repeat (6) @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clock);
            n++;
        end
        repeat (25) @(negedge clock);
        check("ignored_start_dones", done_cnt - dc0, 1);

        // Held start: back-to-back conversions with no idle gap.
        damage_in = 16'd456;
        start     = 1'b1;
        sbq.push_back(model(456));
        @(negedge clock);
        n = 1;
        while (!done && n < 60) begin
            @(negedge clock);
            n++;
        end
        check("held_first_done_cycle", n, 17);
        damage_in = 16'd78;
        sbq.push_back(model(78));
        @(negedge clock);
        check("no_idle_gap_busy", int'(busy), 1);
        start = 1'b0;
        gap = 1;
        while (!done && gap < 60) begin
            @(negedge clock);
            gap++;
        end
        check("b2b_period", gap, 17);

        // Reset at step 8 of 555: outputs hold 0,7,8 until then, then reset, no done.
        @(negedge clock);
        damage_in = 16'd555;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        check("hold_mid_conv", int'({digit100, digit10, digit1}), int'({4'd0, 4'd7, 4'd8}));
        resetn    = 1'b0;
        start     = 1'b1;
        damage_in = 16'd42;
        @(negedge clock);
        check_reset_values("midreset");
        resetn = 1'b1;
        start  = 1'b0;
        dc0 = done_cnt;
        repeat (25) @(negedge clock);
        check("no_done_after_abort", done_cnt - dc0, 0);
        run_one(42, 1'b1);

        // Randomized values, mostly in range, some beyond the saturation point.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 65535);
            else v = $urandom_range(0, 1100);
            run_one(v, 1'b0);
        end

        repeat (3) @(negedge clock);
        check("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
